// File: rtl/race_pkg.sv
// Shared types and constants for the race-test response monitor.
package race_pkg;

   typedef enum logic [1:0] {
      StIdle,
      StFill,
      StCheck,
      StDone
   } state_t;

   // Bit positions inside the 3-bit mismatch / first_err_src vector.
   localparam int unsigned SRC_A     = 0;
   localparam int unsigned SRC_B     = 1;
   localparam int unsigned SRC_SLICE = 2;

   function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
      return (a > b) ? a : b;
   endfunction

endpackage

// File: rtl/race_delay_line.sv
// Reference delay line: tap[k] is the input sampled k cycles ago, tap[0] is the live input.
module race_delay_line #(
   parameter int unsigned WIDTH = 8,
   parameter int unsigned DEPTH = 4
) (
   input  logic                         i_clk,
   input  logic                         i_rst,
   input  logic [WIDTH-1:0]             i_din,
   output logic [DEPTH:0][WIDTH-1:0]    o_taps
);

   logic [DEPTH:1][WIDTH-1:0] r_line;

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_line <= '0;
      end else begin
         r_line[1] <= i_din;
         for (int k = 2; k <= DEPTH; k++) begin
            r_line[k] <= r_line[k-1];
         end
      end
   end

   always_comb begin
      o_taps = {r_line, i_din};
   end

endmodule

// File: rtl/race_monitor.sv
// Checks DUT outputs against a delay-line reference over a fixed window; reports
// pass/fail, a saturating mismatch count and the first failing index/sources.
module race_monitor
   import race_pkg::*;
#(
   parameter  int unsigned WIDTH   = 8,
   parameter  int unsigned LAT_A   = 1,
   parameter  int unsigned LAT_B   = 2,
   parameter  int unsigned MAX_LAT = 4,
   parameter  int unsigned WINDOW  = 64,
   parameter  int unsigned CNT_W   = 16,
   localparam int unsigned IDX_W   = $clog2(WINDOW)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [WIDTH-1:0] in_obs,
   input  logic [WIDTH-1:0] out_a_obs,
   input  logic [WIDTH-1:0] out_b_obs,
   input  logic [WIDTH-1:0] out_slice_obs,
   output logic             busy,
   output logic             done,
   output logic             pass,
   output logic [CNT_W-1:0] err_count,
   output logic [IDX_W-1:0] first_err_cycle,
   output logic [2:0]       first_err_src
);

   localparam int unsigned FILL_LEN = max_u(LAT_A, LAT_B);
   localparam int unsigned FILL_W   = $clog2(FILL_LEN + 1);
   localparam int unsigned HALF     = WIDTH / 2;

   state_t                        r_state, w_state_d;
   logic [FILL_W-1:0]             r_fill, w_fill_d;
   logic [IDX_W-1:0]              r_idx, w_idx_d;
   logic [CNT_W-1:0]              r_err, w_err_d;
   logic [IDX_W-1:0]              r_first_cycle, w_first_cycle_d;
   logic [2:0]                    r_first_src, w_first_src_d;
   logic                          r_pass, w_pass_d;
   logic [MAX_LAT:0][WIDTH-1:0]   w_taps;
   logic [WIDTH-1:0]              w_exp_a, w_exp_b, w_exp_slice;
   logic [2:0]                    w_mism;
   logic                          w_unused_taps;

   race_delay_line #(
      .WIDTH (WIDTH),
      .DEPTH (MAX_LAT)
   ) u_delay_line (
      .i_clk  (clk),
      .i_rst  (rst),
      .i_din  (in_obs),
      .o_taps (w_taps)
   );

   // Only two taps feed the comparison; fold the rest so they are visibly consumed.
   assign w_unused_taps = ^w_taps;

   always_comb begin
      w_exp_a     = w_taps[LAT_A];
      w_exp_b     = w_taps[LAT_B];
      w_exp_slice = {w_exp_a[WIDTH-1:HALF], w_exp_b[HALF-1:0]};
      w_mism            = '0;
      w_mism[SRC_A]     = (out_a_obs != w_exp_a);
      w_mism[SRC_B]     = (out_b_obs != w_exp_b);
      w_mism[SRC_SLICE] = (out_slice_obs != w_exp_slice);
   end

   always_comb begin
      w_state_d       = r_state;
      w_fill_d        = r_fill;
      w_idx_d         = r_idx;
      w_err_d         = r_err;
      w_first_cycle_d = r_first_cycle;
      w_first_src_d   = r_first_src;
      w_pass_d        = r_pass;
      unique case (r_state)
         StIdle: begin
            if (start) begin
               w_state_d       = StFill;
               w_fill_d        = '0;
               w_err_d         = '0;
               w_first_cycle_d = '0;
               w_first_src_d   = '0;
               w_pass_d        = 1'b0;
            end
         end
         StFill: begin
            w_fill_d = r_fill + FILL_W'(1);
            if (r_fill == FILL_W'(FILL_LEN - 1)) begin
               w_state_d = StCheck;
               w_idx_d   = '0;
            end
         end
         StCheck: begin
            if (w_mism != 3'b000) begin
               if (r_err != {CNT_W{1'b1}}) begin
                  w_err_d = r_err + CNT_W'(1);
               end
               // A nonzero count can never return to zero within a run.
               if (r_err == '0) begin
                  w_first_cycle_d = r_idx;
                  w_first_src_d   = w_mism;
               end
            end
            w_idx_d = r_idx + IDX_W'(1);
            if (r_idx == IDX_W'(WINDOW - 1)) begin
               w_state_d = StDone;
               w_pass_d  = (r_err == '0) && (w_mism == 3'b000);
            end
         end
         StDone: begin
            w_state_d = StIdle;
         end
         default: begin
            w_state_d = StIdle;
         end
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state       <= StIdle;
         r_fill        <= '0;
         r_idx         <= '0;
         r_err         <= '0;
         r_first_cycle <= '0;
         r_first_src   <= '0;
         r_pass        <= 1'b0;
      end else begin
         r_state       <= w_state_d;
         r_fill        <= w_fill_d;
         r_idx         <= w_idx_d;
         r_err         <= w_err_d;
         r_first_cycle <= w_first_cycle_d;
         r_first_src   <= w_first_src_d;
         r_pass        <= w_pass_d;
      end
   end

   always_comb begin
      busy            = (r_state == StFill) || (r_state == StCheck);
      done            = (r_state == StDone);
      pass            = r_pass;
      err_count       = r_err;
      first_err_cycle = r_first_cycle;
      first_err_src   = r_first_src;
   end

endmodule

// File: tb/tb_race_monitor.sv
// Self-checking bench for race_monitor: directed table, corner sequences and random runs
// scored against a window-level reference built from the stimulus history.
module tb_race_monitor;

   localparam int W    = 8;
   localparam int LA   = 1;
   localparam int LB   = 2;
   localparam int WIN  = 64;
   localparam int FILL = (LA > LB) ? LA : LB;
   localparam int MAXC = 8192;

   logic       clk = 1'b0;
   logic       rst;
   logic       start;
   logic [W-1:0] in_obs, a_obs, b_obs, s_obs;
   logic       busy, done, pass;
   logic [15:0] err;
   logic [5:0] fcyc;
   logic [2:0] fsrc;
   logic       busy4, done4, pass4;
   logic [3:0] err4;
   logic [5:0] fcyc4;
   logic [2:0] fsrc4;

   always #5 clk = ~clk;

   race_monitor u_dut (
      .clk             (clk),
      .rst             (rst),
      .start           (start),
      .in_obs          (in_obs),
      .out_a_obs       (a_obs),
      .out_b_obs       (b_obs),
      .out_slice_obs   (s_obs),
      .busy            (busy),
      .done            (done),
      .pass            (pass),
      .err_count       (err),
      .first_err_cycle (fcyc),
      .first_err_src   (fsrc)
   );

   race_monitor #(.CNT_W(4)) u_dut4 (
      .clk             (clk),
      .rst             (rst),
      .start           (start),
      .in_obs          (in_obs),
      .out_a_obs       (a_obs),
      .out_b_obs       (b_obs),
      .out_slice_obs   (s_obs),
      .busy            (busy4),
      .done            (done4),
      .pass            (pass4),
      .err_count       (err4),
      .first_err_cycle (fcyc4),
      .first_err_src   (fsrc4)
   );

   typedef struct {
      int         i1;
      logic [2:0] m1;
      int         i2;
      logic [2:0] m2;
      bit         all;
      int         e_err;
      int         e_first;
      logic [2:0] e_src;
      bit         e_pass;
      int         e_err4;
   } vec_t;

   int         total = 0;
   int         bad = 0;
   int         cyc = 0;
   bit         rnd_mode = 1'b0;
   logic [2:0] cmask [WIN];
   logic [W-1:0] ins [MAXC];
   logic [W-1:0] ah  [MAXC];
   logic [W-1:0] bh  [MAXC];
   logic [W-1:0] slh [MAXC];
   vec_t       tbl [7];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0d want %0d (t=%0t)", name, act, exp, $time);
      end
   endtask

   // One clock cycle: a well-behaved DUT (a = in delayed LA, b = in delayed LB) with bit0
   // of each output flipped where m asks for it.
   task automatic do_cycle(input logic st, input logic [2:0] m);
      logic [W-1:0] iv, av, bv, sv;
      if (cyc >= MAXC) begin
         $display("FAIL cycle_budget: got %0d want below %0d", cyc, MAXC);
         $fatal(1);
      end
      iv = rnd_mode ? W'($urandom) : W'(cyc * 2);
      av = (cyc >= LA) ? ins[cyc-LA] : '0;
      bv = (cyc >= LB) ? ins[cyc-LB] : '0;
      sv = {av[W-1:W/2], bv[W/2-1:0]};
      av = av ^ {7'd0, m[0]};
      bv = bv ^ {7'd0, m[1]};
      sv = sv ^ {7'd0, m[2]};
      ins[cyc] = iv;
      ah[cyc]  = av;
      bh[cyc]  = bv;
      slh[cyc] = sv;
      start  = st;
      in_obs = iv;
      a_obs  = av;
      b_obs  = bv;
      s_obs  = sv;
      @(posedge clk);
      #1;
      cyc++;
   endtask

   // Window-level reference: the run accepted at edge s compares edges s+FILL+1 .. s+FILL+WIN.
   task automatic model(input int s, output int n16, output int n4, output int first,
                        output logic [2:0] src, output bit ok);
      int n;
      logic [W-1:0] ea, eb, es;
      logic [2:0]   m;
      n = 0;
      first = 0;
      src = 3'b000;
      for (int i = 0; i < WIN; i++) begin
         int e;
         e  = s + FILL + 1 + i;
         ea = ins[e-LA];
         eb = ins[e-LB];
         es = {ea[W-1:W/2], eb[W/2-1:0]};
         m  = {slh[e] != es, bh[e] != eb, ah[e] != ea};
         if (m != 3'b000) begin
            if (n == 0) begin
               first = i;
               src   = m;
            end
            n++;
         end
      end
      n16 = (n > 65535) ? 65535 : n;
      n4  = (n > 15) ? 15 : n;
      ok  = (n == 0);
   endtask

   task automatic clear_mask();
      for (int i = 0; i < WIN; i++) cmask[i] = 3'b000;
   endtask

   task automatic run(input bit hold, input bit extra);
      int s, dk, n16, n4, first;
      logic [2:0] src;
      bit ok, busy_ok;
      s = cyc;
      do_cycle(1'b1, 3'b000);
      chk("accept_busy", busy, 1);
      chk("accept_err_clr", err, 0);
      chk("accept_pass_clr", pass, 0);
      dk = -1;
      busy_ok = 1'b1;
      for (int k = 1; k <= FILL + WIN + 4; k++) begin
         int idx;
         logic [2:0] m;
         logic st;
         idx = k - FILL - 1;
         m   = (idx >= 0 && idx < WIN) ? cmask[idx] : 3'b000;
         st  = hold || (extra && (k == 1 || k == FILL + 10));
         do_cycle(st, m);
         if (done) begin
            dk = k;
            break;
         end
         if (!busy || !busy4) busy_ok = 1'b0;
      end
      chk("done_latency", dk, FILL + WIN);
      chk("done4_with_done", done4, 1);
      chk("busy_through_run", busy_ok, 1);
      chk("busy_low_in_done", busy, 0);
      model(s, n16, n4, first, src, ok);
      chk("err_count", err, n16);
      chk("err_count_cnt4", err4, n4);
      chk("first_err_cycle", fcyc, first);
      chk("first_err_src", fsrc, src);
      chk("first_err_cycle_cnt4", fcyc4, first);
      chk("first_err_src_cnt4", fsrc4, src);
      chk("pass", pass, ok);
      chk("pass_cnt4", pass4, ok);
      do_cycle(hold, 3'b000);
      chk("done_one_cycle", done, 0);
      if (!hold) chk("idle_after_done", busy, 0);
   endtask

   initial begin
      #1000000;
      $display("FAIL watchdog: got timeout want finish");
      $fatal(1);
   end

   initial begin
      int s, cnt;
      tbl[0] = '{i1: -1, m1: 3'b000, i2: -1, m2: 3'b000, all: 0,
                 e_err: 0,  e_first: 0,  e_src: 3'b000, e_pass: 1, e_err4: 0};
      tbl[1] = '{i1: 5,  m1: 3'b010, i2: -1, m2: 3'b000, all: 0,
                 e_err: 1,  e_first: 5,  e_src: 3'b010, e_pass: 0, e_err4: 1};
      tbl[2] = '{i1: 0,  m1: 3'b001, i2: -1, m2: 3'b000, all: 0,
                 e_err: 1,  e_first: 0,  e_src: 3'b001, e_pass: 0, e_err4: 1};
      tbl[3] = '{i1: 63, m1: 3'b100, i2: -1, m2: 3'b000, all: 0,
                 e_err: 1,  e_first: 63, e_src: 3'b100, e_pass: 0, e_err4: 1};
      tbl[4] = '{i1: 10, m1: 3'b011, i2: -1, m2: 3'b000, all: 0,
                 e_err: 1,  e_first: 10, e_src: 3'b011, e_pass: 0, e_err4: 1};
      tbl[5] = '{i1: -1, m1: 3'b000, i2: -1, m2: 3'b000, all: 1,
                 e_err: 64, e_first: 0,  e_src: 3'b111, e_pass: 0, e_err4: 15};
      tbl[6] = '{i1: 7,  m1: 3'b010, i2: 30, m2: 3'b001, all: 0,
                 e_err: 2,  e_first: 7,  e_src: 3'b010, e_pass: 0, e_err4: 2};

      rst = 1'b1;
      clear_mask();
      do_cycle(1'b0, 3'b000);
      chk("rst_busy", busy, 0);
      chk("rst_done", done, 0);
      chk("rst_pass", pass, 0);
      chk("rst_err", err, 0);
      chk("rst_first_cycle", fcyc, 0);
      chk("rst_first_src", fsrc, 0);
      do_cycle(1'b0, 3'b000);
      rst = 1'b0;
      for (int i = 0; i < 3; i++) do_cycle(1'b0, 3'b000);
      chk("idle_no_start", busy, 0);

      // Directed table.
      for (int r = 0; r < 7; r++) begin
         clear_mask();
         if (tbl[r].all) for (int i = 0; i < WIN; i++) cmask[i] = 3'b111;
         if (tbl[r].i1 >= 0) cmask[tbl[r].i1] = cmask[tbl[r].i1] ^ tbl[r].m1;
         if (tbl[r].i2 >= 0) cmask[tbl[r].i2] = cmask[tbl[r].i2] ^ tbl[r].m2;
         run(1'b0, 1'b0);
         chk("tbl_err", err, tbl[r].e_err);
         chk("tbl_first_cycle", fcyc, tbl[r].e_first);
         chk("tbl_first_src", fsrc, tbl[r].e_src);
         chk("tbl_pass", pass, tbl[r].e_pass);
         chk("tbl_err_cnt4", err4, tbl[r].e_err4);
         do_cycle(1'b0, 3'b000);
         chk("tbl_hold_err", err, tbl[r].e_err);
      end

      // Reset in the middle of CHECK with errors already counted.
      for (int i = 0; i < WIN; i++) cmask[i] = 3'b001;
      do_cycle(1'b1, 3'b000);
      for (int k = 1; k <= FILL + 21; k++) begin
         do_cycle(1'b0, (k - FILL - 1 >= 0) ? cmask[k-FILL-1] : 3'b000);
      end
      chk("live_err_idx20", err, 21);
      chk("live_busy", busy, 1);
      rst = 1'b1;
      #2;
      chk("midrst_busy", busy, 0);
      chk("midrst_done", done, 0);
      chk("midrst_err", err, 0);
      chk("midrst_first_src", fsrc, 0);
      do_cycle(1'b0, 3'b000);
      rst = 1'b0;
      do_cycle(1'b0, 3'b000);
      clear_mask();
      run(1'b0, 1'b0);
      chk("after_rst_pass", pass, 1);

      // Extra start pulses during FILL and CHECK are ignored.
      clear_mask();
      run(1'b0, 1'b1);
      cnt = 0;
      for (int i = 0; i < 6; i++) begin
         do_cycle(1'b0, 3'b000);
         if (done || busy) cnt++;
      end
      chk("no_extra_run", cnt, 0);

      // Start held high across two back-to-back runs.
      clear_mask();
      cmask[3] = 3'b001;
      cmask[9] = 3'b010;
      cmask[40] = 3'b100;
      run(1'b1, 1'b0);
      chk("hold_run1_err", err, 3);
      clear_mask();
      run(1'b1, 1'b0);
      chk("hold_run2_pass", pass, 1);
      do_cycle(1'b0, 3'b000);

      // Random stimulus and random corruption against the window model.
      rnd_mode = 1'b1;
      for (int r = 0; r < 8; r++) begin
         for (int i = 0; i < WIN; i++) begin
            cmask[i] = ($urandom_range(0, 5) == 0) ? 3'($urandom_range(1, 7)) : 3'b000;
         end
         if (r == 3) clear_mask();
         run(r[0], 1'b0);
         s = $urandom_range(0, 2);
         for (int i = 0; i < s; i++) do_cycle(1'b0, 3'b000);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
